// File: rtl/b06_cmp_count.sv
// Datapath companion to the b06 interrupt controller: source compare (eql), terminal-count
// counter FSM (count/cont_eql) and a saturating counter of ackout rising edges.
module b06_cmp_count #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned TERM_DEFAULT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        cc_mux,
    input  logic              enable_count,
    input  logic              ackout,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_c,
    input  logic              ref_load,
    input  logic [DATA_W-1:0] ref_in,
    input  logic              term_load,
    input  logic [CNT_W-1:0]  term_in,
    output logic              eql,
    output logic              cont_eql,
    output logic [CNT_W-1:0]  count,
    output logic [3:0]        ack_cnt
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCount   = 2'b01,
        StHit     = 2'b10,
        StIllegal = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] TermRst = CNT_W'(TERM_DEFAULT);
    localparam logic [CNT_W:0]   OneExt  = (CNT_W+1)'(1);

    state_e              r_state, w_state_next;
    logic [CNT_W-1:0]    r_count, w_count_next;
    logic                r_cont_eql, w_cont_eql_next;
    logic [DATA_W-1:0]   r_ref;
    logic [CNT_W-1:0]    r_term;
    logic                r_eql;
    logic                r_ack_q;
    logic [3:0]          r_ack_cnt;

    logic [DATA_W-1:0]   w_sel;
    logic                w_eql_next;
    logic [CNT_W:0]      w_cnt_ext, w_cnt_inc, w_term_eff;

    // Arithmetic one bit wider than the counter so count+1 can never wrap.
    assign w_cnt_ext  = {1'b0, r_count};
    assign w_cnt_inc  = w_cnt_ext + OneExt;
    assign w_term_eff = (r_term == '0) ? OneExt : {1'b0, r_term};

    always_comb begin
        w_sel = '0;
        case (cc_mux)
            2'b01:   w_sel = data_a;
            2'b10:   w_sel = data_b;
            2'b11:   w_sel = data_c;
            default: w_sel = '0;
        endcase
        w_eql_next = (cc_mux != 2'b00) && (w_sel == r_ref);
    end

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_cont_eql_next = r_cont_eql;
        case (r_state)
            StIdle: begin
                w_count_next    = '0;
                w_cont_eql_next = 1'b0;
                if (enable_count) begin
                    w_count_next = CNT_W'(1);
                    if (w_term_eff == OneExt) begin
                        w_state_next    = StHit;
                        w_cont_eql_next = 1'b1;
                    end else begin
                        w_state_next = StCount;
                    end
                end
            end
            StCount: begin
                if (!enable_count) begin
                    w_state_next    = StIdle;
                    w_count_next    = '0;
                    w_cont_eql_next = 1'b0;
                end else if (w_cnt_ext >= w_term_eff) begin
                    // Terminal lowered below the running count: stop where we are.
                    w_state_next    = StHit;
                    w_cont_eql_next = 1'b1;
                end else if (w_cnt_inc == w_term_eff) begin
                    w_state_next    = StHit;
                    w_count_next    = w_cnt_inc[CNT_W-1:0];
                    w_cont_eql_next = 1'b1;
                end else begin
                    w_count_next = w_cnt_inc[CNT_W-1:0];
                end
            end
            StHit: begin
                w_cont_eql_next = 1'b1;
                if (!enable_count) begin
                    w_state_next    = StIdle;
                    w_count_next    = '0;
                    w_cont_eql_next = 1'b0;
                end
            end
            default: begin
                w_state_next    = StIdle;
                w_count_next    = '0;
                w_cont_eql_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_cont_eql <= 1'b0;
            r_ref      <= '0;
            r_term     <= TermRst;
            r_eql      <= 1'b0;
            r_ack_q    <= 1'b0;
            r_ack_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_cont_eql <= w_cont_eql_next;
            r_eql      <= w_eql_next;
            if (ref_load) begin
                r_ref <= ref_in;
            end
            if (term_load) begin
                r_term <= term_in;
            end
            r_ack_q <= ackout;
            if (ackout && !r_ack_q && (r_ack_cnt != 4'hF)) begin
                r_ack_cnt <= r_ack_cnt + 4'd1;
            end
        end
    end

    assign eql      = r_eql;
    assign cont_eql = r_cont_eql;
    assign count    = r_count;
    assign ack_cnt  = r_ack_cnt;

endmodule

// File: tb/tb_b06_cmp_count.sv
// Directed bench for b06_cmp_count: compare path, counter FSM edge cases, reset, ack counting.
module tb_b06_cmp_count;

    logic       clock;
    logic       reset;
    logic [1:0] cc_mux;
    logic       enable_count;
    logic       ackout;
    logic [7:0] data_a, data_b, data_c;
    logic       ref_load;
    logic [7:0] ref_in;
    logic       term_load;
    logic [3:0] term_in;
    logic       eql;
    logic       cont_eql;
    logic [3:0] count;
    logic [3:0] ack_cnt;

    int n_tests;
    int n_fail;

    b06_cmp_count #(
        .DATA_W      (8),
        .CNT_W       (4),
        .TERM_DEFAULT(4)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .cc_mux      (cc_mux),
        .enable_count(enable_count),
        .ackout      (ackout),
        .data_a      (data_a),
        .data_b      (data_b),
        .data_c      (data_c),
        .ref_load    (ref_load),
        .ref_in      (ref_in),
        .term_load   (term_load),
        .term_in     (term_in),
        .eql         (eql),
        .cont_eql    (cont_eql),
        .count       (count),
        .ack_cnt     (ack_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] c, input logic ce);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_cont"}, 32'(cont_eql), 32'(ce));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; cc_mux = 2'b00; enable_count = 1'b0; ackout = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        ref_load = 1'b0; ref_in = '0; term_load = 1'b0; term_in = '0;
        step();
        step();
        check("rst_eql", 32'(eql), 0);
        check_cnt("rst", 4'd0, 1'b0);
        check("rst_ack", 32'(ack_cnt), 0);
        reset = 1'b0;

        // Compare path; same-cycle load must compare against the old reference (0).
        ref_load = 1'b1; ref_in = 8'h5A; cc_mux = 2'b10; data_b = 8'h5A;
        step();
        check("eql_old_ref", 32'(eql), 0);
        ref_load = 1'b0;
        step();
        check("eql_b_hit", 32'(eql), 1);
        cc_mux = 2'b00;
        step();
        check("eql_none", 32'(eql), 0);
        cc_mux = 2'b01; data_a = 8'h5A;
        step();
        check("eql_a_hit", 32'(eql), 1);
        cc_mux = 2'b11; data_c = 8'h5B;
        step();
        check("eql_c_miss", 32'(eql), 0);
        cc_mux = 2'b00;

        // Count to default terminal 4.
        enable_count = 1'b1;
        step(); check_cnt("run1", 4'd1, 1'b0);
        step(); check_cnt("run2", 4'd2, 1'b0);
        step(); check_cnt("run3", 4'd3, 1'b0);
        step(); check_cnt("run4", 4'd4, 1'b1);
        step(); check_cnt("hold4", 4'd4, 1'b1);
        enable_count = 1'b0;
        step(); check_cnt("stop", 4'd0, 1'b0);

        // Terminal 0 behaves as 1.
        term_load = 1'b1; term_in = 4'd0;
        step();
        term_load = 1'b0; enable_count = 1'b1;
        step(); check_cnt("t0_first", 4'd1, 1'b1);
        step(); check_cnt("t0_hold", 4'd1, 1'b1);
        enable_count = 1'b0;
        step(); check_cnt("t0_stop", 4'd0, 1'b0);

        // Terminal lowered below the running count.
        term_load = 1'b1; term_in = 4'd8;
        step();
        term_load = 1'b0; enable_count = 1'b1;
        step();
        step(); check_cnt("low_c2", 4'd2, 1'b0);
        term_load = 1'b1; term_in = 4'd2;
        step(); check_cnt("low_c3", 4'd3, 1'b0);
        term_load = 1'b0;
        step(); check_cnt("low_hit", 4'd3, 1'b1);
        enable_count = 1'b0;
        step(); check_cnt("low_stop", 4'd0, 1'b0);

        // Mid-count reset wins over loads.
        term_load = 1'b1; term_in = 4'd8;
        step();
        term_load = 1'b0; enable_count = 1'b1;
        step();
        step(); check_cnt("mr_c2", 4'd2, 1'b0);
        reset = 1'b1; ref_load = 1'b1; ref_in = 8'h77; term_load = 1'b1; term_in = 4'd1;
        cc_mux = 2'b01; data_a = 8'h77;
        step();
        check_cnt("mr_rst", 4'd0, 1'b0);
        check("mr_eql", 32'(eql), 0);
        reset = 1'b0; ref_load = 1'b0; term_load = 1'b0; data_a = 8'h00;
        step(); check_cnt("mr_run1", 4'd1, 1'b0);
        check("mr_ref0", 32'(eql), 1);
        step();
        step(); check_cnt("mr_run3", 4'd3, 1'b0);
        step(); check_cnt("mr_run4", 4'd4, 1'b1);
        enable_count = 1'b0; cc_mux = 2'b00;
        step();

        // Ack edge counting with saturation.
        for (int i = 0; i < 17; i++) begin
            ackout = 1'b1;
            step();
            ackout = 1'b0;
            step();
            if (i == 13) check("ack_14", 32'(ack_cnt), 14);
        end
        check("ack_sat", 32'(ack_cnt), 15);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ack_rst", 32'(ack_cnt), 0);
        ackout = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("ack_level", 32'(ack_cnt), 1);
        ackout = 1'b0;
        step();
        ackout = 1'b1;
        step();
        check("ack_second", 32'(ack_cnt), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/b06_cmp_count.md
Name: b06_cmp_count

Overview:
Datapath companion to the b06 interrupt-handler FSM. It selects a data word according to cc_mux and compares it against a programmable reference to produce eql. It runs the enable_count-driven counter that raises cont_eql at a programmable terminal value. It also tracks acknowledge (ackout) rising edges.
Consumes cc_mux, enable_count and ackout from the controller; feeds eql and cont_eql back to it.

Parameters:
DATA_W, 8, width of data sources and reference register
CNT_W, 4, width of counter and terminal register
TERM_DEFAULT, 4, terminal-register reset value

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cc_mux  input  2  source select: 00 none, 01 data_a, 10 data_b, 11 data_c
enable_count  input  1  counter run request from controller
ackout  input  1  acknowledge level from controller
data_a  input  DATA_W  source 1
data_b  input  DATA_W  source 2
data_c  input  DATA_W  source 3
ref_load  input  1  load ref_in into reference register
ref_in  input  DATA_W  reference value
term_load  input  1  load term_in into terminal register
term_in  input  CNT_W  terminal count value
eql  output  1  registered compare result
cont_eql  output  1  registered terminal-count flag
count  output  CNT_W  current counter value
ack_cnt  output  4  saturating count of ackout rising edges

Behaviour:
- One clock; reset is synchronous and active-high; ports named clock and reset.
- Reset has priority over all other inputs, including ref_load and term_load.
- Reset values: ref_q=0, term_q=TERM_DEFAULT, eql=0, cont_eql=0, count=0, state=IDLE, ack_cnt=0, ackout_q=0.
- Reset asserted mid-count forces the reset values on the next edge.
- ref_q <= ref_in when ref_load; term_q <= term_in when term_load. New values are first used on the following cycle.
- sel = data_a / data_b / data_c for cc_mux 01 / 10 / 11.
- eql <= (cc_mux != 00) && (sel == ref_q), using the old ref_q when ref_load is high in the same cycle. Latency: 1 cycle.
- Effective terminal: term_eff = (term_q == 0) ? 1 : term_q. Counter arithmetic is done in CNT_W+1 bits, so there is no wrap.
- FSM, 2-bit state encoding:
  - IDLE (00): count=0, cont_eql=0. On enable_count: if term_eff==1 -> HIT with count<=1, cont_eql<=1; else -> COUNT with count<=1.
  - COUNT (01): enable_count=0 -> IDLE, count<=0.
    Else if count >= term_eff (term lowered mid-run) -> HIT, count held, cont_eql<=1.
    Else if count+1 == term_eff -> HIT, count<=count+1, cont_eql<=1.
    Else count<=count+1.
  - HIT (10): count held, cont_eql=1. enable_count=0 -> IDLE, count<=0, cont_eql<=0. term_load is ignored in this state for the transition.
  - Encoding 11 is illegal -> IDLE with count<=0, cont_eql<=0.
- cont_eql is a register and is high exactly while state==HIT.
- ack tracking: ackout_q <= ackout each cycle. When ackout && !ackout_q, ack_cnt <= ack_cnt+1, saturating at 15.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> eql=0, cont_eql=0, count=0, ack_cnt=0; term_q=4.
- Compare: ref_load with ref_in=0x5A; next cycle cc_mux=10, data_b=0x5A -> eql=1 one cycle later. Then cc_mux=00 with same data -> eql=0.
- Count to terminal: term=4, enable_count held high -> count 1,2,3,4. cont_eql rises on the edge where count becomes 4 and stays high. enable_count low -> next edge count=0, cont_eql=0.
- Term edge cases:
  - term_in=0 -> first enable cycle gives count=1, cont_eql=1.
  - In COUNT at count=3, load term=2 -> next edge HIT with count=3.
- Mid-operation reset: count=2 in COUNT, reset=1 with ref_load=1 and term_load=1 -> all reset values, loads ignored.
- Ack saturation: 17 ackout pulses (1 high, 1 low each) -> ack_cnt=15. A held ackout level counts once.
